// File: rtl/pic_pkg.sv
// pic_pkg: shared constants and types for the 14-bit PIC-style core.
//   ADDR_W/DATA_W  program address and instruction widths
//   NOP_WORD       word injected into the instruction register on flush/reset
//   fetch_state_t  fetch sequencer states
//   OP_*           opcode patterns the decoder matches to raise jump/call/ret/sleep
package pic_pkg;

    localparam int unsigned ADDR_W = 11;
    localparam int unsigned DATA_W = 14;
    localparam logic [13:0] NOP_WORD = 14'h0000;

    typedef enum logic [1:0] {
        FILL  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        HALT  = 2'd3
    } fetch_state_t;

    // Control-transfer opcodes (top bits for GOTO/CALL, full word otherwise)
    localparam logic [2:0]  OP_GOTO_HI = 3'b101;   // 10 1kkk kkkk kkkk
    localparam logic [2:0]  OP_CALL_HI = 3'b100;   // 10 0kkk kkkk kkkk
    localparam logic [13:0] OP_RETURN  = 14'h0008;
    localparam logic [13:0] OP_SLEEP   = 14'h0063;

    function automatic logic is_goto(input logic [13:0] word);
        return word[13:11] == OP_GOTO_HI;
    endfunction

    function automatic logic is_call(input logic [13:0] word);
        return word[13:11] == OP_CALL_HI;
    endfunction

endpackage

// File: rtl/pic_ret_stack.sv
// pic_ret_stack: circular return-address LIFO.
//   clk, rst        clock, synchronous active-high reset
//   push, pop       mutually exclusive per cycle (push wins if both)
//   push_data       address pushed on push
//   top             mem[sp-1], the value a pop returns
//   sp              write pointer, modulo DEPTH
//   stk_ovf/stk_unf sticky overflow/underflow flags, only when
//                   PIC_FETCH_STACK_CHK_EN is defined
module pic_ret_stack #(
    parameter int unsigned DEPTH  = 8,
    parameter int unsigned ADDR_W = 11
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [ADDR_W-1:0]          push_data,
    output logic [ADDR_W-1:0]          top,
`ifdef PIC_FETCH_STACK_CHK_EN
    output logic                       stk_ovf,
    output logic                       stk_unf,
`endif
    output logic [$clog2(DEPTH)-1:0]   sp
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  sp_prev;

    // Pointer arithmetic wraps naturally: pop on empty reads mem[DEPTH-1]
    assign sp_prev = sp - PTR_ONE;
    assign top     = mem[sp_prev];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[sp] <= push_data;
            sp      <= sp + PTR_ONE;
        end else if (pop) begin
            sp <= sp_prev;
        end
    end

`ifdef PIC_FETCH_STACK_CHK_EN
    localparam logic [PTR_W:0] LIVE_FULL = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] LIVE_ONE  = (PTR_W+1)'(1);

    // Live count saturates at both ends; the pointer itself keeps wrapping
    logic [PTR_W:0] live;

    always_ff @(posedge clk) begin
        if (rst) begin
            live    <= '0;
            stk_ovf <= 1'b0;
            stk_unf <= 1'b0;
        end else if (push) begin
            if (live == LIVE_FULL) begin
                stk_ovf <= 1'b1;
            end else begin
                live <= live + LIVE_ONE;
            end
        end else if (pop) begin
            if (live == '0) begin
                stk_unf <= 1'b1;
            end else begin
                live <= live - LIVE_ONE;
            end
        end
    end
`endif

endmodule

// File: rtl/pic_fetch_ctrl.sv
// pic_fetch_ctrl: instruction-fetch sequencer for the 14-bit PIC-style core.
//   clk, rst         clock, synchronous active-high reset
//   rom_addr/rom_data combinational program ROM interface (rom_addr = pc)
//   ir, ir_valid, ir_pc  fetched instruction, validity, and its address
//   stall            freeze all fetch state for the cycle
//   jump/call/ret, target  control transfers (priority ret > call > jump)
//   sleep/wake, halted     HALT entry/exit and status
//   stk_ovf/stk_unf  return-stack check flags, present only when
//                    PIC_FETCH_STACK_CHK_EN is defined
module pic_fetch_ctrl #(
    parameter int unsigned       ADDR_W      = pic_pkg::ADDR_W,
    parameter int unsigned       DATA_W      = pic_pkg::DATA_W,
    parameter int unsigned       STACK_DEPTH = 8,
    parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
    parameter logic [DATA_W-1:0] NOP_WORD    = '0
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [DATA_W-1:0] rom_data,
    output logic [DATA_W-1:0] ir,
    output logic              ir_valid,
    output logic [ADDR_W-1:0] ir_pc,
    input  logic              stall,
    input  logic              jump,
    input  logic              call,
    input  logic              ret,
    input  logic [ADDR_W-1:0] target,
    input  logic              sleep,
    input  logic              wake,
`ifdef PIC_FETCH_STACK_CHK_EN
    output logic              stk_ovf,
    output logic              stk_unf,
`endif
    output logic              halted
);

    import pic_pkg::*;

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    fetch_state_t              state;
    logic [ADDR_W-1:0]         pc;
    logic [ADDR_W-1:0]         stk_top;
    logic [$clog2(STACK_DEPTH)-1:0] stk_sp;
    logic                      run_ctl;
    logic                      stk_push;
    logic                      stk_pop;

    assign rom_addr = pc;

    // Stack moves only when the request actually wins arbitration in RUN
    assign run_ctl  = !rst && !stall && (state == RUN) && !sleep;
    assign stk_pop  = run_ctl && ret;
    assign stk_push = run_ctl && !ret && call;

    pic_ret_stack #(
        .DEPTH  (STACK_DEPTH),
        .ADDR_W (ADDR_W)
    ) u_stack (
        .clk       (clk),
        .rst       (rst),
        .push      (stk_push),
        .pop       (stk_pop),
        .push_data (pc),
        .top       (stk_top),
`ifdef PIC_FETCH_STACK_CHK_EN
        .stk_ovf   (stk_ovf),
        .stk_unf   (stk_unf),
`endif
        .sp        (stk_sp)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= RESET_VEC;
            ir       <= NOP_WORD;
            ir_valid <= 1'b0;
            ir_pc    <= '0;
            halted   <= 1'b0;
            state    <= FILL;
        end else if (!stall) begin
            case (state)
                FILL, FLUSH: begin
                    ir       <= rom_data;
                    ir_pc    <= pc;
                    ir_valid <= 1'b1;
                    pc       <= pc + PC_ONE;
                    state    <= RUN;
                end
                RUN: begin
                    if (sleep) begin
                        ir       <= NOP_WORD;
                        ir_valid <= 1'b0;
                        halted   <= 1'b1;
                        state    <= HALT;
                    end else if (ret || call || jump) begin
                        pc       <= ret ? stk_top : target;
                        ir       <= NOP_WORD;
                        ir_valid <= 1'b0;
                        state    <= FLUSH;
                    end else begin
                        ir       <= rom_data;
                        ir_pc    <= pc;
                        ir_valid <= 1'b1;
                        pc       <= pc + PC_ONE;
                    end
                end
                HALT: begin
                    if (wake) begin
                        halted <= 1'b0;
                        state  <= FLUSH;
                    end
                end
                default: state <= FILL;
            endcase
        end
    end

endmodule

// File: tb/tb_pic_fetch_ctrl.sv
// tb_pic_fetch_ctrl: directed bench for pic_fetch_ctrl (table of vectors plus
// hand-written multi-cycle sequences). Define PIC_FETCH_STACK_CHK_EN to also
// exercise the stack check flags.
module tb_pic_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst, stall, jump, call, ret, sleep, wake;
    logic [10:0] target;
    logic [10:0] rom_addr;
    logic [13:0] rom_data;
    logic [13:0] ir;
    logic        ir_valid;
    logic [10:0] ir_pc;
    logic        halted;
`ifdef PIC_FETCH_STACK_CHK_EN
    logic        stk_ovf, stk_unf;
`endif

    logic [13:0] rom [2048];
    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    pic_fetch_ctrl #(
        .ADDR_W      (11),
        .DATA_W      (14),
        .STACK_DEPTH (8),
        .RESET_VEC   (11'h000),
        .NOP_WORD    (14'h0000)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_pc    (ir_pc),
        .stall    (stall),
        .jump     (jump),
        .call     (call),
        .ret      (ret),
        .target   (target),
        .sleep    (sleep),
        .wake     (wake),
`ifdef PIC_FETCH_STACK_CHK_EN
        .stk_ovf  (stk_ovf),
        .stk_unf  (stk_unf),
`endif
        .halted   (halted)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Drive one cycle of inputs, then sample 1 time unit after the edge
    task automatic cyc(input logic r, input logic s, input logic j, input logic c,
                       input logic rt, input logic sl, input logic w,
                       input logic [10:0] tg);
        rst = r; stall = s; jump = j; call = c; ret = rt; sleep = sl; wake = w;
        target = tg;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 11'h000);
    endtask

    typedef struct {
        logic        rst, jump, call, ret;
        logic [10:0] target;
        logic [13:0] e_ir;
        logic        e_valid;
        logic [10:0] e_ir_pc;
        logic [10:0] e_addr;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic j, input logic c, input logic rt,
                                input logic [10:0] tg, input logic [13:0] e_ir,
                                input logic e_v, input logic [10:0] e_pc,
                                input logic [10:0] e_a);
        vec_t v;
        v.rst = r; v.jump = j; v.call = c; v.ret = rt; v.target = tg;
        v.e_ir = e_ir; v.e_valid = e_v; v.e_ir_pc = e_pc; v.e_addr = e_a;
        return v;
    endfunction

    localparam int NVEC = 23;
    vec_t vecs [NVEC];

    logic [10:0] pushed [9];
    logic [10:0] exp_ret;

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = 14'h2000 | 14'(i);
        rom[0] = 14'h3044; rom[1] = 14'h3E01; rom[2] = 14'h3802; rom[3] = 14'h39FE;
        rom[4] = 14'h3C47; rom[5] = 14'h3A55; rom[6] = 14'h3AAA;

        //               rst j c r  tgt     ir        v  ir_pc   addr
        // straight-line fetch
        vecs[0]  = mk(1, 0, 0, 0, 11'h000, 14'h0000, 0, 11'h000, 11'h000);
        vecs[1]  = mk(0, 0, 0, 0, 11'h000, 14'h3044, 1, 11'h000, 11'h001);
        vecs[2]  = mk(0, 0, 0, 0, 11'h000, 14'h3E01, 1, 11'h001, 11'h002);
        vecs[3]  = mk(0, 0, 0, 0, 11'h000, 14'h3802, 1, 11'h002, 11'h003);
        vecs[4]  = mk(0, 0, 0, 0, 11'h000, 14'h39FE, 1, 11'h003, 11'h004);
        vecs[5]  = mk(0, 0, 0, 0, 11'h000, 14'h3C47, 1, 11'h004, 11'h005);
        vecs[6]  = mk(0, 0, 0, 0, 11'h000, 14'h3A55, 1, 11'h005, 11'h006);
        vecs[7]  = mk(0, 0, 0, 0, 11'h000, 14'h3AAA, 1, 11'h006, 11'h007);
        // jump to 5 while ir_pc=2
        vecs[8]  = mk(1, 0, 0, 0, 11'h000, 14'h0000, 0, 11'h000, 11'h000);
        vecs[9]  = mk(0, 0, 0, 0, 11'h000, 14'h3044, 1, 11'h000, 11'h001);
        vecs[10] = mk(0, 0, 0, 0, 11'h000, 14'h3E01, 1, 11'h001, 11'h002);
        vecs[11] = mk(0, 0, 0, 0, 11'h000, 14'h3802, 1, 11'h002, 11'h003);
        vecs[12] = mk(0, 1, 0, 0, 11'h005, 14'h0000, 0, 11'h002, 11'h005);
        vecs[13] = mk(0, 0, 0, 0, 11'h000, 14'h3A55, 1, 11'h005, 11'h006);
        vecs[14] = mk(0, 0, 0, 0, 11'h000, 14'h3AAA, 1, 11'h006, 11'h007);
        // call 4 at ir_pc=1 (pushes 2), then ret
        vecs[15] = mk(1, 0, 0, 0, 11'h000, 14'h0000, 0, 11'h000, 11'h000);
        vecs[16] = mk(0, 0, 0, 0, 11'h000, 14'h3044, 1, 11'h000, 11'h001);
        vecs[17] = mk(0, 0, 0, 0, 11'h000, 14'h3E01, 1, 11'h001, 11'h002);
        vecs[18] = mk(0, 0, 1, 0, 11'h004, 14'h0000, 0, 11'h001, 11'h004);
        vecs[19] = mk(0, 0, 0, 0, 11'h000, 14'h3C47, 1, 11'h004, 11'h005);
        vecs[20] = mk(0, 0, 0, 0, 11'h000, 14'h3A55, 1, 11'h005, 11'h006);
        vecs[21] = mk(0, 0, 0, 1, 11'h000, 14'h0000, 0, 11'h005, 11'h002);
        vecs[22] = mk(0, 0, 0, 0, 11'h000, 14'h3802, 1, 11'h002, 11'h003);

        rst = 1; stall = 0; jump = 0; call = 0; ret = 0; sleep = 0; wake = 0;
        target = '0;
        #2;

        for (int i = 0; i < NVEC; i++) begin
            cyc(vecs[i].rst, 0, vecs[i].jump, vecs[i].call, vecs[i].ret, 0, 0, vecs[i].target);
            chk($sformatf("vec%0d ir", i),       ir,       vecs[i].e_ir);
            chk($sformatf("vec%0d ir_valid", i), ir_valid, vecs[i].e_valid);
            chk($sformatf("vec%0d ir_pc", i),    ir_pc,    vecs[i].e_ir_pc);
            chk($sformatf("vec%0d rom_addr", i), rom_addr, vecs[i].e_addr);
            chk($sformatf("vec%0d halted", i),   halted,   0);
        end
        chk("callret sp", u_dut.stk_sp, 0);

        // stall with jump held: everything frozen, jump dropped
        cyc(1, 0, 0, 0, 0, 0, 0, 11'h000);
        idle();
        idle();
        for (int k = 0; k < 3; k++) begin
            cyc(0, 1, 1, 0, 0, 0, 0, 11'h010);
            chk("stall ir", ir, 14'h3E01);
            chk("stall ir_pc", ir_pc, 11'h001);
            chk("stall rom_addr", rom_addr, 11'h002);
            chk("stall ir_valid", ir_valid, 1);
        end
        cyc(0, 0, 1, 0, 0, 0, 0, 11'h010);
        chk("unstall jump ir_valid", ir_valid, 0);
        chk("unstall jump rom_addr", rom_addr, 11'h010);
        idle();
        chk("unstall jump ir", ir, 14'h2010);
        chk("unstall jump ir_pc", ir_pc, 11'h010);

        // ret+call together: ret wins, pops reset-zero entry, no push
        cyc(1, 0, 0, 0, 0, 0, 0, 11'h000);
        idle();
        cyc(0, 0, 0, 1, 1, 0, 0, 11'h020);
        chk("retcall rom_addr", rom_addr, 11'h000);
        chk("retcall sp", u_dut.stk_sp, 7);
        idle();
        chk("retcall ir", ir, 14'h3044);
        chk("retcall ir_pc", ir_pc, 11'h000);

        // stack wrap: 9 nested calls then 9 rets
        cyc(1, 0, 0, 0, 0, 0, 0, 11'h000);
        idle();
        for (int i = 0; i < 9; i++) begin
            pushed[i] = (i == 0) ? 11'h001 : 11'(32'h101 + 16 * (i - 1));
            cyc(0, 0, 0, 1, 0, 0, 0, 11'(32'h100 + 16 * i));
`ifdef PIC_FETCH_STACK_CHK_EN
            if (i == 7) chk("ovf before 9th call", stk_ovf, 0);
            if (i == 8) chk("ovf after 9th call", stk_ovf, 1);
`endif
            idle();
            chk($sformatf("wrap call%0d ir_pc", i), ir_pc, 32'h100 + 16 * i);
        end
        chk("wrap sp", u_dut.stk_sp, 1);
        for (int j = 0; j < 9; j++) begin
            exp_ret = (j == 0 || j == 8) ? pushed[8] : pushed[8 - j];
            cyc(0, 0, 0, 0, 1, 0, 0, 11'h000);
`ifdef PIC_FETCH_STACK_CHK_EN
            if (j == 7) chk("unf before 9th ret", stk_unf, 0);
            if (j == 8) chk("unf after 9th ret", stk_unf, 1);
`endif
            idle();
            chk($sformatf("wrap ret%0d ir_pc", j), ir_pc, exp_ret);
        end

        // sleep at ir_pc=3, hold, wake, then reset during HALT
        cyc(1, 0, 0, 0, 0, 0, 0, 11'h000);
        idle();
        idle();
        idle();
        idle();
        chk("pre-sleep ir_pc", ir_pc, 11'h003);
        cyc(0, 0, 0, 0, 0, 1, 0, 11'h000);
        chk("sleep halted", halted, 1);
        chk("sleep ir_valid", ir_valid, 0);
        chk("sleep rom_addr", rom_addr, 11'h004);
        for (int k = 0; k < 5; k++) begin
            cyc(0, 0, 1, 0, 0, 0, 0, 11'h030);
            chk("halt halted", halted, 1);
            chk("halt rom_addr", rom_addr, 11'h004);
            chk("halt ir_valid", ir_valid, 0);
        end
        cyc(0, 0, 0, 0, 0, 0, 1, 11'h000);
        chk("wake halted", halted, 0);
        chk("wake ir_valid", ir_valid, 0);
        idle();
        chk("wake ir", ir, 14'h3C47);
        chk("wake ir_pc", ir_pc, 11'h004);
        chk("wake ir_valid after flush", ir_valid, 1);
        cyc(0, 0, 0, 0, 0, 1, 0, 11'h000);
        chk("resleep halted", halted, 1);
        cyc(1, 0, 0, 0, 0, 0, 1, 11'h000);
        chk("rst in halt halted", halted, 0);
        chk("rst in halt rom_addr", rom_addr, 11'h000);
        chk("rst in halt ir", ir, 14'h0000);
        idle();
        chk("fill after rst ir", ir, 14'h3044);
        chk("fill after rst ir_pc", ir_pc, 11'h000);
        chk("fill after rst ir_valid", ir_valid, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
